// File: rtl/cpu_datamem_pkg.sv
// cpu_datamem_pkg: default geometry and request struct for the multi-port CPU data memory.
package cpu_datamem_pkg;

   localparam int DM_ADDR_W   = 16;
   localparam int DM_WR_BYTES = 4;
   localparam int DM_RD_BYTES = 64;

   typedef struct packed {
      logic                     we;
      logic [DM_ADDR_W-1:0]     addr;
      logic [DM_WR_BYTES*8-1:0] wdata;
      logic [DM_WR_BYTES-1:0]   be;
   } dm_req_t;

endpackage

// File: rtl/cpu_datamem_if.sv
// cpu_datamem_if: per-channel request/response bundle of cpu_datamem_mp.
interface cpu_datamem_if
   import cpu_datamem_pkg::*;
#(
   parameter int ADDR_W   = DM_ADDR_W,
   parameter int NUM_CH   = 2,
   parameter int WR_BYTES = DM_WR_BYTES,
   parameter int RD_BYTES = DM_RD_BYTES
) ();

   logic [NUM_CH-1:0]                   req_valid;
   logic [NUM_CH-1:0]                   req_ready;
   logic [NUM_CH-1:0]                   req_we;
   logic [NUM_CH-1:0][ADDR_W-1:0]       req_addr;
   logic [NUM_CH-1:0][WR_BYTES*8-1:0]   req_wdata;
   logic [NUM_CH-1:0][WR_BYTES-1:0]     req_be;
   logic [NUM_CH-1:0]                   rsp_valid;
   logic [NUM_CH-1:0]                   rsp_err;
   logic [RD_BYTES*8-1:0]               rsp_rdata;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_err, rsp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_err, rsp_rdata
   );

endinterface

// File: rtl/cpu_datamem_arb.sv
// cpu_datamem_arb: NUM_CH-way arbiter, one-hot grant plus index.
// CPU_DATAMEM_RR_ARB_EN selects round-robin; otherwise lowest channel wins.
module cpu_datamem_arb
   import cpu_datamem_pkg::*;
#(
   parameter  int NUM_CH = 2,
   localparam int IW     = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] valid_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [IW-1:0]     idx_o
);

`ifdef CPU_DATAMEM_RR_ARB_EN
   logic [IW-1:0] ptr_q, ptr_d;

   // Scan from lowest priority to highest so the last hit wins.
   always_comb begin
      idx_o = '0;
      for (int k = NUM_CH - 1; k >= 0; k--)
         if (valid_i[(int'(ptr_q) + k) % NUM_CH]) idx_o = IW'((int'(ptr_q) + k) % NUM_CH);
      ptr_d = !(|valid_i) ? ptr_q : (int'(idx_o) == NUM_CH - 1 ? '0 : idx_o + 1'b1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`else
   always_comb begin
      idx_o = '0;
      for (int k = NUM_CH - 1; k >= 0; k--)
         if (valid_i[k]) idx_o = IW'(k);
   end
`endif

   assign gnt_o = |valid_i ? NUM_CH'(1) << idx_o : '0;

endmodule

// File: rtl/cpu_datamem_mp.sv
// cpu_datamem_mp: multi-port byte-addressed data memory, narrow byte-enabled writes,
// wide registered reads, per-channel range errors. CPU_DATAMEM_RR_ARB_EN enables round-robin.
module cpu_datamem_mp
   import cpu_datamem_pkg::*;
#(
   parameter  int ADDR_W   = DM_ADDR_W,
   parameter  int NUM_CH   = 2,
   parameter  int WR_BYTES = DM_WR_BYTES,
   parameter  int RD_BYTES = DM_RD_BYTES,
   localparam int IW       = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   cpu_datamem_if.slave  bus
);

   localparam logic [ADDR_W:0] WR_LIM = (ADDR_W + 1)'((1 << ADDR_W) - WR_BYTES);
   localparam logic [ADDR_W:0] RD_LIM = (ADDR_W + 1)'((1 << ADDR_W) - RD_BYTES);

   logic [7:0]              mem [1 << ADDR_W];
   logic [NUM_CH-1:0]       gnt;
   logic [IW-1:0]           idx;
   logic                    acc, we, err;
   logic [ADDR_W:0]         a_ext;
   logic [RD_BYTES*8-1:0]   rd_word;
   logic [NUM_CH-1:0]       rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
   logic [RD_BYTES*8-1:0]   rdata_q, rdata_d;

   cpu_datamem_arb #(.NUM_CH(NUM_CH)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (bus.req_valid),
      .gnt_o   (gnt),
      .idx_o   (idx)
   );

   assign bus.req_ready = rst_n ? gnt : '0;
   assign acc           = |bus.req_ready;
   assign we            = bus.req_we[idx];
   // One extra address bit keeps the range checks from wrapping.
   assign a_ext         = {1'b0, bus.req_addr[idx]};
   assign err           = we ? a_ext > WR_LIM : a_ext > RD_LIM;

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < RD_BYTES; i++)
         rd_word[8*i +: 8] = mem[ADDR_W'(a_ext + (ADDR_W + 1)'(i))];
      rsp_valid_d = bus.req_ready;
      rsp_err_d   = err ? bus.req_ready : '0;
      rdata_d     = (acc && !we && !err) ? rd_word : '0;
   end

   // Storage is deliberately outside reset.
   always_ff @(posedge clk) begin
      if (acc && we && !err)
         for (int i = 0; i < WR_BYTES; i++)
            if (bus.req_be[idx][i])
               mem[ADDR_W'(a_ext + (ADDR_W + 1)'(i))] <= bus.req_wdata[idx][8*i +: 8];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid_q <= '0;
         rsp_err_q   <= '0;
         rdata_q     <= '0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = rdata_q;

endmodule
